// File: rtl/risc_controller.sv
// risc_controller
//   Multi-cycle Moore sequencer for the 16-bit RISC datapath. Holds the
//   instruction register (IR), decodes it and steps the datapath through
//   read-A, read-B, compute and write-back for one instruction at a time.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in, load          instruction word and IR capture strobe (WAIT only)
//   s                 start execution of IR (WAIT only)
//   w                 idle in WAIT, ready for s
//   illegal           one-cycle pulse in DECODE for an undefined encoding
//   readnum/writenum  register-file read/write index
//   write             register-file write strobe
//   loada/loadb/loadc A/B/C register load strobes
//   loads             status flag load (CMP only)
//   asel/bsel         ALU operand selects (A forced to 0 / B = sximm5)
//   shift, ALUop      shifter and ALU controls
//   vsel              write-back source: 00 mdata, 01 sximm8, 10 PC, 11 C
//   sximm5/sximm8     sign-extended IR[4:0] / IR[7:0]
module risc_controller #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      in,
    input  logic             load,
    input  logic             s,
    output logic             w,
    output logic             illegal,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic             loadc,
    output logic             loads,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [1:0]       vsel,
    output logic [width-1:0] sximm5,
    output logic [width-1:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_COMPUTE,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    typedef enum logic [2:0] {
        K_MOVI,
        K_MOVR,
        K_ADD,
        K_CMP,
        K_AND,
        K_MVN,
        K_ILL
    } kind_t;

    typedef struct packed {
        logic       w;
        logic       illegal;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic [1:0] vsel;
    } ctrl_t;

    state_t      state;
    logic [15:0] ir;
    ctrl_t       ctrl;

    function automatic kind_t f_kind(input logic [4:0] opfield);
        kind_t k;
        k = K_ILL;
        case (opfield[4:2])
            3'b110: begin
                if (opfield[1:0] == 2'b10)      k = K_MOVI;
                else if (opfield[1:0] == 2'b00) k = K_MOVR;
            end
            3'b101: begin
                case (opfield[1:0])
                    2'b00:   k = K_ADD;
                    2'b01:   k = K_CMP;
                    2'b10:   k = K_AND;
                    default: k = K_MVN;
                endcase
            end
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic state_t f_next_state(input state_t st, input kind_t k,
                                            input logic go);
        state_t n;
        n = S_WAIT;
        case (st)
            S_WAIT:    n = go ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case (k)
                    K_MOVI:                n = S_WRITE_IMM;
                    K_MOVR, K_MVN:         n = S_GET_B;
                    K_ADD, K_CMP, K_AND:   n = S_GET_A;
                    default:               n = S_WAIT;
                endcase
            end
            S_GET_A:   n = S_GET_B;
            S_GET_B:   n = S_COMPUTE;
            S_COMPUTE: n = (k == K_CMP) ? S_WAIT : S_WRITE_REG;
            default:   n = S_WAIT;
        endcase
        return n;
    endfunction

    function automatic ctrl_t f_outputs(input state_t st, input logic [15:0] v);
        ctrl_t o;
        kind_t k;
        o = '0;
        k = f_kind(v[15:11]);
        case (st)
            S_WAIT:   o.w = 1'b1;
            S_DECODE: o.illegal = (k == K_ILL);
            S_GET_A: begin
                o.readnum = v[10:8];
                o.loada   = 1'b1;
            end
            S_GET_B: begin
                o.readnum = v[2:0];
                o.loadb   = 1'b1;
            end
            S_COMPUTE: begin
                o.shift = v[4:3];
                o.loadc = 1'b1;
                case (k)
                    K_MOVR: begin
                        o.asel  = 1'b1;
                        o.aluop = 2'b00;
                    end
                    K_MVN: begin
                        o.asel  = 1'b1;
                        o.aluop = 2'b11;
                    end
                    K_CMP: begin
                        o.aluop = 2'b01;
                        o.loads = 1'b1;
                    end
                    default: o.aluop = v[12:11];
                endcase
            end
            S_WRITE_REG: begin
                o.writenum = v[7:5];
                o.vsel     = 2'b11;
                o.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                o.writenum = v[10:8];
                o.vsel     = 2'b01;
                o.write    = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Outputs are registered: each edge stores the decode of the state being
    // entered, using the IR value that state will see (a same-edge load
    // included), so the outputs stay a pure function of state and IR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
            ctrl  <= f_outputs(S_WAIT, 16'h0000);
        end else begin
            state <= f_next_state(state, f_kind(ir[15:11]), s);
            if (state == S_WAIT && load)
                ir <= in;
            ctrl  <= f_outputs(f_next_state(state, f_kind(ir[15:11]), s),
                               (state == S_WAIT && load) ? in : ir);
        end
    end

    assign w        = ctrl.w;
    assign illegal  = ctrl.illegal;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign write    = ctrl.write;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign asel     = ctrl.asel;
    assign bsel     = ctrl.bsel;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign shift    = ctrl.shift;
    assign ALUop    = ctrl.aluop;
    assign vsel     = ctrl.vsel;

    assign sximm5 = {{(width-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(width-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_risc_controller.sv
module tb_risc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w, illegal, write, loada, loadb, asel, bsel, loadc, loads;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, aluop, vsel;
    logic [15:0] sximm5, sximm8;

    risc_controller #(.width(16)) dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
        .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .loadc(loadc), .loads(loads), .shift(shift), .ALUop(aluop), .vsel(vsel),
        .sximm5(sximm5), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] ctl;
        logic [15:0] sx5;
        logic [15:0] sx8;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nmis = 0;
    int   cur_tag = 0;

    // {w, illegal, readnum, writenum, write, loada, loadb, asel, bsel,
    //  loadc, loads, shift, aluop, vsel}
    function automatic logic [20:0] c(input logic cw, input logic ill,
                                      input logic [2:0] rn, input logic [2:0] wn,
                                      input logic wr, input logic la, input logic lb,
                                      input logic as, input logic bs, input logic lc,
                                      input logic ls, input logic [1:0] sh,
                                      input logic [1:0] op, input logic [1:0] vs);
        return {cw, ill, rn, wn, wr, la, lb, as, bs, lc, ls, sh, op, vs};
    endfunction

    logic [20:0] IDLE, DEC, ILL;

    task automatic push(input logic [20:0] ctl, input logic [15:0] e5,
                        input logic [15:0] e8);
        exp_t e;
        e.ctl = ctl; e.sx5 = e5; e.sx8 = e8; e.tag = cur_tag;
        q.push_back(e);
        cur_tag++;
    endtask

    // Monitor: one expected snapshot per cycle while the scoreboard is non-empty.
    initial begin
        exp_t e;
        logic [20:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                act = {w, illegal, readnum, writenum, write, loada, loadb, asel,
                       bsel, loadc, loads, shift, aluop, vsel};
                nvec++;
                if (act !== e.ctl || sximm5 !== e.sx5 || sximm8 !== e.sx8) begin
                    nmis++;
                    $display("FAIL vec%0d: got ctl=%b sx5=%h sx8=%h, want ctl=%b sx5=%h sx8=%h",
                             e.tag, act, sximm5, sximm8, e.ctl, e.sx5, e.sx8);
                end
            end
        end
    end

    // Called at posedge+2: present instruction for one edge, then release.
    task automatic issue(input logic [15:0] instr, input logic go);
        in = instr; load = 1'b1; s = go;
        @(posedge clk); #2;
        load = 1'b0; s = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (q.size() != 0 && i < 40) begin
            @(posedge clk);
            i++;
        end
        if (q.size() != 0) begin
            nmis++;
            $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
            q.delete();
        end
        #2;
    endtask

    initial begin
        IDLE = c(1,0,3'd0,3'd0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00);
        DEC  = c(0,0,3'd0,3'd0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00);
        ILL  = c(0,1,3'd0,3'd0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00);
        reset = 1'b1; in = 16'h0000; load = 1'b0; s = 1'b0;

        // Reset state
        @(posedge clk); #2;
        push(IDLE, 16'h0000, 16'h0000);
        @(posedge clk); #2;
        reset = 1'b0;

        // 1: MOV R0,#7 with load and s together
        cur_tag = 100;
        push(IDLE, 16'h0000, 16'h0000);
        push(DEC,  16'h0007, 16'h0007);
        push(c(0,0,3'd0,3'd0,1,0,0,0,0,0,0,2'b00,2'b00,2'b01), 16'h0007, 16'h0007);
        push(IDLE, 16'h0007, 16'h0007);
        issue(16'hD007, 1'b1); drain();

        // 2: MOV R1,#-2
        cur_tag = 200;
        push(IDLE, 16'h0007, 16'h0007);
        push(DEC,  16'hFFFE, 16'hFFFE);
        push(c(0,0,3'd0,3'd1,1,0,0,0,0,0,0,2'b00,2'b00,2'b01), 16'hFFFE, 16'hFFFE);
        push(IDLE, 16'hFFFE, 16'hFFFE);
        issue(16'hD1FE, 1'b1); drain();

        // 3: ADD R2,R1,R0,LSL#1
        cur_tag = 300;
        push(IDLE, 16'hFFFE, 16'hFFFE);
        push(DEC,  16'h0008, 16'h0048);
        push(c(0,0,3'd1,3'd0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00), 16'h0008, 16'h0048);
        push(c(0,0,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00), 16'h0008, 16'h0048);
        push(c(0,0,3'd0,3'd0,0,0,0,0,0,1,0,2'b01,2'b00,2'b00), 16'h0008, 16'h0048);
        push(c(0,0,3'd0,3'd2,1,0,0,0,0,0,0,2'b00,2'b00,2'b11), 16'h0008, 16'h0048);
        push(IDLE, 16'h0008, 16'h0048);
        issue(16'hA148, 1'b1); drain();

        // 4: CMP R0,R1 - flags only, no write
        cur_tag = 400;
        push(IDLE, 16'h0008, 16'h0048);
        push(DEC,  16'h0001, 16'h0001);
        push(c(0,0,3'd0,3'd0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00), 16'h0001, 16'h0001);
        push(c(0,0,3'd1,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00), 16'h0001, 16'h0001);
        push(c(0,0,3'd0,3'd0,0,0,0,0,0,1,1,2'b00,2'b01,2'b00), 16'h0001, 16'h0001);
        push(IDLE, 16'h0001, 16'h0001);
        issue(16'hA801, 1'b1); drain();

        // 5: opcode 000 is illegal
        cur_tag = 500;
        push(IDLE, 16'h0001, 16'h0001);
        push(ILL,  16'h0000, 16'h0000);
        push(IDLE, 16'h0000, 16'h0000);
        issue(16'h0000, 1'b1); drain();

        // 6: opcode 110 with op 01 is illegal
        cur_tag = 600;
        push(IDLE, 16'h0000, 16'h0000);
        push(ILL,  16'h0000, 16'h0000);
        push(IDLE, 16'h0000, 16'h0000);
        issue(16'hC800, 1'b1); drain();

        // 7: MOV R5,R6,ASR
        cur_tag = 700;
        push(IDLE, 16'h0000, 16'h0000);
        push(DEC,  16'hFFFE, 16'hFFBE);
        push(c(0,0,3'd6,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00), 16'hFFFE, 16'hFFBE);
        push(c(0,0,3'd0,3'd0,0,0,0,1,0,1,0,2'b11,2'b00,2'b00), 16'hFFFE, 16'hFFBE);
        push(c(0,0,3'd0,3'd5,1,0,0,0,0,0,0,2'b00,2'b00,2'b11), 16'hFFFE, 16'hFFBE);
        push(IDLE, 16'hFFFE, 16'hFFBE);
        issue(16'hC0BE, 1'b1); drain();

        // 8: MVN R7,R3,LSR
        cur_tag = 800;
        push(IDLE, 16'hFFFE, 16'hFFBE);
        push(DEC,  16'hFFF3, 16'hFFF3);
        push(c(0,0,3'd3,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00), 16'hFFF3, 16'hFFF3);
        push(c(0,0,3'd0,3'd0,0,0,0,1,0,1,0,2'b10,2'b11,2'b00), 16'hFFF3, 16'hFFF3);
        push(c(0,0,3'd0,3'd7,1,0,0,0,0,0,0,2'b00,2'b00,2'b11), 16'hFFF3, 16'hFFF3);
        push(IDLE, 16'hFFF3, 16'hFFF3);
        issue(16'hB8F3, 1'b1); drain();

        // 9: ADD again; s/load with 0xFFFF while busy must be ignored
        cur_tag = 900;
        push(IDLE, 16'hFFF3, 16'hFFF3);
        push(DEC,  16'h0008, 16'h0048);
        push(c(0,0,3'd1,3'd0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00), 16'h0008, 16'h0048);
        push(c(0,0,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00), 16'h0008, 16'h0048);
        push(c(0,0,3'd0,3'd0,0,0,0,0,0,1,0,2'b01,2'b00,2'b00), 16'h0008, 16'h0048);
        push(c(0,0,3'd0,3'd2,1,0,0,0,0,0,0,2'b00,2'b00,2'b11), 16'h0008, 16'h0048);
        push(IDLE, 16'h0008, 16'h0048);
        push(IDLE, 16'h0008, 16'h0048);
        in = 16'hA148; load = 1'b1; s = 1'b1;
        @(posedge clk); #2;
        in = 16'hFFFF; load = 1'b1; s = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        load = 1'b0; s = 1'b0; in = 16'h0000;
        drain();

        // 10: reset during GET_B of ADD
        cur_tag = 1000;
        push(IDLE, 16'h0008, 16'h0048);
        push(DEC,  16'h0008, 16'h0048);
        push(c(0,0,3'd1,3'd0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00), 16'h0008, 16'h0048);
        push(c(0,0,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00), 16'h0008, 16'h0048);
        push(IDLE, 16'h0000, 16'h0000);
        push(IDLE, 16'h0000, 16'h0000);
        issue(16'hA148, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        drain();

        // 11: load without s only updates IR
        cur_tag = 1100;
        push(IDLE, 16'h0000, 16'h0000);
        push(IDLE, 16'hFFFE, 16'hFFFE);
        push(IDLE, 16'hFFFE, 16'hFFFE);
        issue(16'hD1FE, 1'b0); drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
Multi-cycle Moore sequencer that drives the 16-bit RISC datapath through one instruction at a time. Holds a 16-bit instruction register and decodes the opcode, register fields, shift field and immediates. Steps the datapath through read-A, read-B, compute and write-back using the datapath's register-file, ALU and write-select strobes. Sits between the instruction source (start/load handshake) and the datapath control inputs.

Parameters:
width, 16, datapath word width; the instruction encoding is fixed at 16 bits, so only 16 is supported.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in  input  16  instruction word to capture
load  input  1  capture in into instruction register (IR)
s  input  1  start execution of IR
w  output  1  1 = idle in WAIT, ready for s
illegal  output  1  one-cycle pulse in DECODE for an undefined encoding
readnum  output  3  register-file read index
writenum  output  3  register-file write index
write  output  1  register write strobe
loada  output  1  load A register
loadb  output  1  load B register
asel  output  1  1 = ALU A operand forced to 0
bsel  output  1  1 = ALU B operand is sximm5
loadc  output  1  load C register
loads  output  1  load status flags
shift  output  2  shifter control, equal to IR[4:3]
ALUop  output  2  ALU operation
vsel  output  2  write-back source: 00 mdata, 01 sximm8, 10 PC, 11 C
sximm5  output  16  sign-extended IR[4:0]
sximm8  output  16  sign-extended IR[7:0]

Behaviour:
- IR fields:
  - opcode = IR[15:13]
  - op = IR[12:11]
  - Rn = IR[10:8]
  - Rd = IR[7:5]
  - sh = IR[4:3]
  - Rm = IR[2:0]
- sximm5 = {11{IR[4]}, IR[4:0]}; sximm8 = {8{IR[7]}, IR[7:0]}. Both combinational from IR.
- IR loads on the clk edge when load=1 and state=WAIT. load is ignored in any other state.
- load and s asserted together in WAIT: the new IR value is the one decoded.
- Reset:
  - state = WAIT, IR = 0.
  - w = 1; all strobes, illegal, asel, bsel = 0.
  - readnum, writenum, shift, ALUop, vsel = 0.
- Outputs are decoded from state and IR only. Any output not listed for a state is 0.
- Supported encodings:
  - MOV imm: 110/10. Rn ← sximm8.
  - MOV reg: 110/00. Rd ← sh(Rm).
  - ALU: 101/op. ADD=00, CMP=01, AND=10, MVN=11.
  - Everything else is illegal.
- WAIT: w=1. If s=1 → DECODE; otherwise stay.
- DECODE: no strobes. Next state:
  - MOV imm → WRITE_IMM
  - MOV reg, MVN → GET_B
  - ADD, CMP, AND → GET_A
  - illegal → illegal=1, next WAIT
- GET_A: readnum=Rn, loada=1 → GET_B.
- GET_B: readnum=Rm, loadb=1 → COMPUTE.
- COMPUTE: shift=sh, bsel=0, loadc=1.
  - MOV reg: asel=1, ALUop=00.
  - MVN: asel=1, ALUop=11.
  - ADD/AND: asel=0, ALUop=op.
  - CMP: asel=0, ALUop=01, loads=1, loadc still 1.
  - Next: CMP → WAIT; else → WRITE_REG.
- WRITE_REG: writenum=Rd, vsel=11, write=1 → WAIT.
- WRITE_IMM: writenum=Rn, vsel=01, write=1 → WAIT.
- Non-WAIT cycles per instruction:
  - MOV imm: 2
  - MOV reg: 4
  - MVN: 4
  - CMP: 4
  - ADD/AND: 5
  - illegal: 1
- s outside WAIT is ignored, not queued.
- Exactly one write pulse per writing instruction. CMP never writes. loads only pulses for CMP.
- Reset in any state overrides all else. The next cycle is WAIT with reset outputs, and no pending write or load completes.
- Unknown state encodings recover to WAIT on the next edge.

Test Plan:
1. Reset, then load in=0xD007 and s=1 → DECODE; WRITE_IMM: write=1, writenum=0, vsel=01, sximm8=0x0007; next cycle w=1.
2. Execute in=0xD1FE (MOV R1,#-2) → sximm8=0xFFFE, writenum=1, write for exactly 1 cycle, 2 busy cycles.
3. Execute in=0xA148 (ADD R2,R1,R0,LSL#1) → GET_A readnum=1 loada=1; GET_B readnum=0 loadb=1; COMPUTE shift=01 ALUop=00 asel=0 loadc=1; WRITE_REG writenum=2 vsel=11 write=1; 5 busy cycles.
4. Execute in=0xA801 (CMP R0,R1) → COMPUTE loads=1 loadc=1 ALUop=01; write never asserted; w=1 after 4 busy cycles.
5. Execute in=0x0000 → illegal=1 for one cycle in DECODE, no other strobes, w=1 next cycle. Then, during a busy ADD, pulse s and load with in=0xFFFF → both ignored; IR still 0xA148.
6. Assert reset during GET_B of 0xA148 → next cycle w=1, all strobes 0, IR=0; write never pulses.
